// File: rtl/spi_reg_bank_pkg.sv
// rtl/spi_reg_bank_pkg.sv - shared state type, constants and frame helper for spi_reg_bank
package spi_reg_bank_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, ABORT} spi_state_t;

  localparam logic RW_WRITE = 1'b1;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_reg_bank_sync_edge.sv
// rtl/spi_reg_bank_sync_edge.sv - spi_sync_edge: 2-flop synchroniser plus history flop with edge detect
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {3{RESET_VAL}};
    else        sync_q <= {sync_q[1:0], din};
  end

  // edges come from the second sync stage against the history flop
  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI mode-0 register bank with read-back and write strobe
// Optional error counter at address NUM_REGS: SPI_REG_BANK_ERR_CNT_EN
module spi_reg_bank
  import spi_reg_bank_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_LAST_ADDR  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FIRST_DATA = CNT_W'(ADDR_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL       = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT        = CNT_W'(FRAME_W + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic sync_unused;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .din(ncs), .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall));
  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .din(copi), .level(copi_lvl), .rise(copi_rise), .fall(copi_fall));

  assign sync_unused = ^{sclk_lvl, copi_rise, copi_fall};

  spi_state_t                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q;
  logic [FRAME_W-1:0]         sr_q;
  logic [DATA_W-1:0]          out_q;
  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic                       fall_pend_q;
  logic                       start, frame_end, commit_wr, wr_hit;
  logic [DATA_W-1:0]          rd_data;
  logic [ADDR_W:0]            live_frame;

`ifdef SPI_REG_BANK_ERR_CNT_EN
  localparam logic [ADDR_W:0] ERR_ADDR = (ADDR_W + 1)'(NUM_REGS);
  logic [7:0] err_cnt_q;
`endif

  // a fall seen during COMMIT/ABORT is remembered for one cycle
  assign start      = (ncs_fall | fall_pend_q) & ~ncs_lvl;
  assign frame_end  = (state_q == SHIFT) && ncs_rise;
  assign commit_wr  = (state_q == COMMIT) && (sr_q[FRAME_W-1] == RW_WRITE);
  assign live_frame = {sr_q[ADDR_W-1:0], copi_lvl};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:          if (start) state_d = SHIFT;
      SHIFT:         if (ncs_rise) state_d = (cnt_q == CNT_FULL) ? COMMIT : ABORT;
      COMMIT, ABORT: state_d = IDLE;
      default:       state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_hit  = 1'b0;
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sr_q[DATA_W +: ADDR_W] == ADDR_W'(i)) wr_hit = 1'b1;
      if (live_frame[ADDR_W-1:0] == ADDR_W'(i)) rd_data = regs_q[i*DATA_W +: DATA_W];
    end
`ifdef SPI_REG_BANK_ERR_CNT_EN
    if ({1'b0, live_frame[ADDR_W-1:0]} == ERR_ADDR) rd_data = DATA_W'(err_cnt_q);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      sr_q        <= '0;
      out_q       <= '0;
      cipo_oe     <= 1'b0;
      fall_pend_q <= 1'b0;
    end else begin
      fall_pend_q <= ncs_fall;
      if (state_q == IDLE && start) begin
        cnt_q <= '0;
        sr_q  <= '0;
      end else if (frame_end) begin
        cipo_oe <= 1'b0;
        out_q   <= '0;
      end else if (state_q == SHIFT) begin
        if (sclk_rise) begin
          if (cnt_q != CNT_SAT) cnt_q <= cnt_q + CNT_W'(1);
          sr_q <= sr_q << 1 | FRAME_W'(copi_lvl);
          if (cnt_q == CNT_LAST_ADDR && live_frame[ADDR_W] != RW_WRITE) begin
            out_q   <= rd_data;
            cipo_oe <= 1'b1;
          end
        end else if (sclk_fall && cipo_oe && cnt_q > CNT_FIRST_DATA) begin
          // the fall right after loading is skipped so the MSB meets the first data rise
          out_q <= out_q << 1;
        end
      end
    end
  end

  assign cipo = out_q[DATA_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q    <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (commit_wr && wr_hit) begin
        wr_strobe <= 1'b1;
        wr_addr   <= sr_q[DATA_W +: ADDR_W];
        for (int i = 0; i < NUM_REGS; i++)
          if (sr_q[DATA_W +: ADDR_W] == ADDR_W'(i)) regs_q[i*DATA_W +: DATA_W] <= sr_q[DATA_W-1:0];
      end
    end
  end

  assign regs_flat = regs_q;

`ifdef SPI_REG_BANK_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else if (commit_wr && {1'b0, sr_q[DATA_W +: ADDR_W]} == ERR_ADDR) err_cnt_q <= '0;
    else if ((state_q == ABORT) || (commit_wr && !wr_hit)) begin
      if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end
`endif

endmodule
